// File: rtl/btn_press_seq.sv
// Button-press sequencer: drives timed press/release waveforms, with optional
// contact-bounce emulation, onto CHANNELS button lines after a trigger.
module btn_press_seq #(
  parameter int CHANNELS   = 2,
  parameter int CNT_W      = 16,
  parameter int AUTO       = 1,
  parameter int START_DLY  = 15,
  parameter int PRESS_CYC  = 50,
  parameter int GAP_CYC    = 2000,
  parameter int REPEAT     = 2,
  parameter int BOUNCE_EN  = 0,
  parameter int BOUNCE_CYC = 4,
  parameter int BOUNCE_N   = 3
) (
  input  logic                CLK50MHZ,
  input  logic                RST,
  input  logic                START,
  input  logic [CHANNELS-1:0] CH_MASK,
  output logic [CHANNELS-1:0] BTN,
  output logic                BUSY,
  output logic                DONE,
  output logic [CNT_W-1:0]    PRESS_CNT
);

  localparam longint MAX_CNT = (longint'(1) << CNT_W) - 1;
  localparam int HALF_W = $clog2(2 * BOUNCE_N) + 1;

  localparam logic [CNT_W-1:0]  DLY_LOAD   = CNT_W'(START_DLY - 1);
  localparam logic [CNT_W-1:0]  PRESS_LOAD = CNT_W'(PRESS_CYC - 1);
  localparam logic [CNT_W-1:0]  GAP_LOAD   = CNT_W'(GAP_CYC - 1);
  localparam logic [CNT_W-1:0]  BNC_LOAD   = CNT_W'(BOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0]  REP_LAST   = CNT_W'(REPEAT);
  localparam logic [HALF_W-1:0] LAST_HALF  = HALF_W'(2 * BOUNCE_N - 1);

  // Bad configurations are rejected while the design is being elaborated.
  if (START_DLY < 1 || PRESS_CYC < 1 || GAP_CYC < 1 || REPEAT < 1 ||
      BOUNCE_CYC < 1 || BOUNCE_N < 1 ||
      START_DLY > MAX_CNT || PRESS_CYC > MAX_CNT || GAP_CYC > MAX_CNT ||
      REPEAT > MAX_CNT || BOUNCE_CYC > MAX_CNT) begin : g_cfg_error
    $error("btn_press_seq: timing parameter out of range for CNT_W");
  end

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    BNC_ON,
    HOLD,
    BNC_OFF,
    GAP
  } state_t;

  state_t              state;
  logic [CNT_W-1:0]    timer;
  logic [HALF_W-1:0]   half;
  logic [CHANNELS-1:0] mask_r;
  logic                armed;

  logic                timer_done;
  logic [HALF_W-1:0]   half_next;
  logic [CNT_W-1:0]    cnt_next;
  logic                trigger;
  logic                bounce_on;

  assign timer_done = (timer == '0);
  assign half_next  = half + 1'b1;
  assign cnt_next   = PRESS_CNT + 1'b1;
  assign bounce_on  = (BOUNCE_EN != 0);
  // In AUTO mode the trigger is armed by reset and fires once on release.
  assign trigger    = (AUTO != 0) ? armed : START;

  always_ff @(posedge CLK50MHZ) begin
    if (RST) begin
      state     <= IDLE;
      timer     <= '0;
      half      <= '0;
      mask_r    <= '0;
      armed     <= 1'b1;
      BTN       <= '0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      PRESS_CNT <= '0;
    end else begin
      DONE <= 1'b0;
      case (state)
        IDLE: begin
          if (trigger) begin
            mask_r    <= CH_MASK;
            BUSY      <= 1'b1;
            PRESS_CNT <= '0;
            armed     <= 1'b0;
            timer     <= DLY_LOAD;
            state     <= WAIT;
          end
        end

        WAIT, GAP: begin
          if (timer_done) begin
            BTN  <= mask_r;
            half <= '0;
            if (bounce_on) begin
              timer <= BNC_LOAD;
              state <= BNC_ON;
            end else begin
              timer <= PRESS_LOAD;
              state <= HOLD;
            end
          end else begin
            timer <= timer - 1'b1;
          end
        end

        // Even half-periods carry the mask, odd ones drop back to 0.
        BNC_ON: begin
          if (timer_done) begin
            if (half == LAST_HALF) begin
              BTN   <= mask_r;
              timer <= PRESS_LOAD;
              state <= HOLD;
            end else begin
              half  <= half_next;
              BTN   <= half_next[0] ? '0 : mask_r;
              timer <= BNC_LOAD;
            end
          end else begin
            timer <= timer - 1'b1;
          end
        end

        HOLD: begin
          if (timer_done) begin
            BTN <= '0;
            if (bounce_on) begin
              half  <= '0;
              timer <= BNC_LOAD;
              state <= BNC_OFF;
            end else begin
              PRESS_CNT <= cnt_next;
              if (cnt_next == REP_LAST) begin
                BUSY  <= 1'b0;
                DONE  <= 1'b1;
                state <= IDLE;
              end else begin
                timer <= GAP_LOAD;
                state <= GAP;
              end
            end
          end else begin
            timer <= timer - 1'b1;
          end
        end

        BNC_OFF: begin
          if (timer_done) begin
            if (half == LAST_HALF) begin
              BTN       <= '0;
              PRESS_CNT <= cnt_next;
              if (cnt_next == REP_LAST) begin
                BUSY  <= 1'b0;
                DONE  <= 1'b1;
                state <= IDLE;
              end else begin
                timer <= GAP_LOAD;
                state <= GAP;
              end
            end else begin
              half  <= half_next;
              BTN   <= half_next[0] ? mask_r : '0;
              timer <= BNC_LOAD;
            end
          end else begin
            timer <= timer - 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_btn_press_seq.sv
// Randomised scoreboard bench for btn_press_seq: four differently configured
// sequencers share reset/start/mask and are checked against an arithmetic timeline model.
module tb_btn_press_seq;

  localparam int ND = 4;

  // dut0: minimum timings, no bounce, START-triggered
  localparam int D0_AUTO = 0, D0_SD = 1, D0_PC = 1, D0_GC = 1, D0_REP = 3;
  localparam int D0_BEN = 0, D0_BC = 4, D0_BN = 3;
  // dut1: short bounced presses, START-triggered
  localparam int D1_AUTO = 0, D1_SD = 2, D1_PC = 6, D1_GC = 3, D1_REP = 2;
  localparam int D1_BEN = 1, D1_BC = 2, D1_BN = 2;
  // dut2: default configuration, self-starting after reset
  localparam int D2_AUTO = 1, D2_SD = 15, D2_PC = 50, D2_GC = 2000, D2_REP = 2;
  localparam int D2_BEN = 0, D2_BC = 4, D2_BN = 3;
  // dut3: default timing with bounce, single press, self-starting
  localparam int D3_AUTO = 1, D3_SD = 15, D3_PC = 50, D3_GC = 2000, D3_REP = 1;
  localparam int D3_BEN = 1, D3_BC = 4, D3_BN = 3;

  typedef struct {
    int auto_m;
    int sd;
    int pc;
    int gc;
    int rep;
    int ben;
    int bc;
    int bn;
  } cfg_t;

  typedef struct {
    int d;
    int cyc;
    int cnt;
  } done_t;

  logic       clock;
  logic       rst;
  logic       start;
  logic [1:0] ch_mask;

  logic [1:0]  btn  [ND];
  logic        busy [ND];
  logic        done [ND];
  logic [15:0] pcnt [ND];

  // model state
  int         cyc;
  bit         seen_reset;
  bit         valid [ND];
  bit         armed [ND];
  int         trig  [ND];
  logic [1:0] mask  [ND];
  done_t      done_q[$];

  int checks;
  int failures;

  btn_press_seq #(.CHANNELS(2), .CNT_W(16), .AUTO(D0_AUTO), .START_DLY(D0_SD),
    .PRESS_CYC(D0_PC), .GAP_CYC(D0_GC), .REPEAT(D0_REP), .BOUNCE_EN(D0_BEN),
    .BOUNCE_CYC(D0_BC), .BOUNCE_N(D0_BN)) dut0 (
    .CLK50MHZ(clock), .RST(rst), .START(start), .CH_MASK(ch_mask),
    .BTN(btn[0]), .BUSY(busy[0]), .DONE(done[0]), .PRESS_CNT(pcnt[0]));

  btn_press_seq #(.CHANNELS(2), .CNT_W(16), .AUTO(D1_AUTO), .START_DLY(D1_SD),
    .PRESS_CYC(D1_PC), .GAP_CYC(D1_GC), .REPEAT(D1_REP), .BOUNCE_EN(D1_BEN),
    .BOUNCE_CYC(D1_BC), .BOUNCE_N(D1_BN)) dut1 (
    .CLK50MHZ(clock), .RST(rst), .START(start), .CH_MASK(ch_mask),
    .BTN(btn[1]), .BUSY(busy[1]), .DONE(done[1]), .PRESS_CNT(pcnt[1]));

  btn_press_seq #(.CHANNELS(2), .CNT_W(16), .AUTO(D2_AUTO), .START_DLY(D2_SD),
    .PRESS_CYC(D2_PC), .GAP_CYC(D2_GC), .REPEAT(D2_REP), .BOUNCE_EN(D2_BEN),
    .BOUNCE_CYC(D2_BC), .BOUNCE_N(D2_BN)) dut2 (
    .CLK50MHZ(clock), .RST(rst), .START(start), .CH_MASK(ch_mask),
    .BTN(btn[2]), .BUSY(busy[2]), .DONE(done[2]), .PRESS_CNT(pcnt[2]));

  btn_press_seq #(.CHANNELS(2), .CNT_W(16), .AUTO(D3_AUTO), .START_DLY(D3_SD),
    .PRESS_CYC(D3_PC), .GAP_CYC(D3_GC), .REPEAT(D3_REP), .BOUNCE_EN(D3_BEN),
    .BOUNCE_CYC(D3_BC), .BOUNCE_N(D3_BN)) dut3 (
    .CLK50MHZ(clock), .RST(rst), .START(start), .CH_MASK(ch_mask),
    .BTN(btn[3]), .BUSY(busy[3]), .DONE(done[3]), .PRESS_CNT(pcnt[3]));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic cfg_t cfgOf(input int d);
    cfg_t c;
    case (d)
      0:       c = '{D0_AUTO, D0_SD, D0_PC, D0_GC, D0_REP, D0_BEN, D0_BC, D0_BN};
      1:       c = '{D1_AUTO, D1_SD, D1_PC, D1_GC, D1_REP, D1_BEN, D1_BC, D1_BN};
      2:       c = '{D2_AUTO, D2_SD, D2_PC, D2_GC, D2_REP, D2_BEN, D2_BC, D2_BN};
      default: c = '{D3_AUTO, D3_SD, D3_PC, D3_GC, D3_REP, D3_BEN, D3_BC, D3_BN};
    endcase
    return c;
  endfunction

  // Cycles from the trigger edge to the edge carrying DONE.
  function automatic int seqLen(input cfg_t c);
    int b;
    b = c.ben ? 2 * c.bn * c.bc : 0;
    return c.sd + c.rep * (c.pc + 2 * b) + (c.rep - 1) * c.gc;
  endfunction

  // Expected outputs just after edge n, from the press timeline of the active sequence.
  function automatic void expState(input int d, input int n,
                                   output logic [1:0] eb, output logic ebusy,
                                   output int ecnt, output logic edone);
    cfg_t c;
    int b, per, len, o, k, x;
    c = cfgOf(d);
    eb = 2'b00; ebusy = 1'b0; ecnt = 0; edone = 1'b0;
    if (!valid[d]) return;
    b   = c.ben ? 2 * c.bn * c.bc : 0;
    per = c.pc + c.gc + 2 * b;
    len = seqLen(c);
    o   = n - trig[d];
    if (o >= len) begin
      ecnt  = c.rep;
      edone = (o == len);
      return;
    end
    ebusy = 1'b1;
    if (o < c.sd) return;
    k = (o - c.sd) / per;
    x = (o - c.sd) % per;
    if (x < b)
      eb = ((x / c.bc) % 2 == 0) ? mask[d] : 2'b00;
    else if (x < b + c.pc)
      eb = mask[d];
    else if (x < 2 * b + c.pc)
      eb = (((x - b - c.pc) / c.bc) % 2 == 0) ? 2'b00 : mask[d];
    ecnt = k + ((x >= 2 * b + c.pc) ? 1 : 0);
  endfunction

  function automatic bit idleAt(input int d, input int n);
    return !valid[d] || (n - trig[d] >= seqLen(cfgOf(d)));
  endfunction

  // Reference model: follows the bench's own pin drive at every active edge.
  initial begin
    done_t e;
    bit    fire;
    cyc = 0;
    seen_reset = 1'b0;
    for (int d = 0; d < ND; d++) begin
      valid[d] = 1'b0;
      armed[d] = 1'b0;
      trig[d]  = 0;
      mask[d]  = 2'b00;
    end
    forever begin
      @(posedge clock);
      cyc = cyc + 1;
      if (rst) begin
        seen_reset = 1'b1;
        done_q.delete();
        for (int d = 0; d < ND; d++) begin
          valid[d] = 1'b0;
          armed[d] = 1'b1;
        end
      end else begin
        for (int d = 0; d < ND; d++) begin
          if (cfgOf(d).auto_m != 0)
            fire = armed[d];
          else
            fire = start && idleAt(d, cyc - 1);
          if (fire) begin
            valid[d] = 1'b1;
            armed[d] = 1'b0;
            trig[d]  = cyc;
            mask[d]  = ch_mask;
            e.d   = d;
            e.cyc = cyc + seqLen(cfgOf(d));
            e.cnt = cfgOf(d).rep;
            done_q.push_back(e);
          end
        end
      end
    end
  end

  task automatic checkOutput(input int d);
    logic [1:0] eb;
    logic       ebusy, edone;
    int         ecnt, idx;
    expState(d, cyc, eb, ebusy, ecnt, edone);
    checks++;
    if (btn[d] !== eb || busy[d] !== ebusy || pcnt[d] !== 16'(ecnt) || done[d] !== edone) begin
      failures++;
      $display("[TB] FAIL dut%0d state cyc=%0d got btn=%b busy=%b cnt=%0d done=%b exp btn=%b busy=%b cnt=%0d done=%b",
               d, cyc, btn[d], busy[d], pcnt[d], done[d], eb, ebusy, ecnt, edone);
    end
    if (done[d] === 1'b1) begin
      idx = -1;
      for (int i = 0; i < done_q.size(); i++)
        if (idx < 0 && done_q[i].d == d) idx = i;
      checks++;
      if (idx < 0) begin
        failures++;
        $display("[TB] FAIL dut%0d done_unexpected got cyc=%0d exp none", d, cyc);
      end else begin
        if (done_q[idx].cyc != cyc || pcnt[d] !== 16'(done_q[idx].cnt)) begin
          failures++;
          $display("[TB] FAIL dut%0d done_timing got cyc=%0d cnt=%0d exp cyc=%0d cnt=%0d",
                   d, cyc, pcnt[d], done_q[idx].cyc, done_q[idx].cnt);
        end
        done_q.delete(idx);
      end
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  initial begin
    checks   = 0;
    failures = 0;
    forever begin
      @(negedge clock);
      if (seen_reset)
        for (int d = 0; d < ND; d++) checkOutput(d);
    end
  end

  task automatic applyStimulus(input int ncyc, input int start_rate);
    for (int i = 0; i < ncyc; i++) begin
      @(posedge clock);
      #1;
      start   = (start_rate > 0) && ($urandom_range(0, start_rate - 1) == 0);
      ch_mask = 2'($urandom);
    end
  endtask

  task automatic applyReset(input int ncyc);
    rst   = 1'b1;
    start = 1'b0;
    repeat (ncyc) begin
      @(posedge clock);
      #1;
    end
    rst = 1'b0;
  endtask

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    ch_mask = 2'b11;
    repeat (5) @(posedge clock);
    #1 rst = 1'b0;
    $display("[TB] reset released, self-starting units triggered with mask 11");
    applyStimulus(30, 6);
    $display("[TB] reset during the first press");
    applyReset(2);
    applyStimulus(2300, 6);
    $display("[TB] second reset, full sequences to completion");
    applyReset(1);
    applyStimulus(2300, 5);
    applyStimulus(60, 0);
    @(negedge clock);
    #1;
    checks++;
    if (done_q.size() != 0) begin
      failures++;
      foreach (done_q[i])
        $display("[TB] FAIL dut%0d done_missing got none exp cyc=%0d", done_q[i].d, done_q[i].cyc);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
